// File: rtl/fft_bank_writer.sv
// fft_bank_writer: streams FFT output bins into NO_BANKS spectrum RAM banks
// in round-robin order. Each bank holds FFTS_PER_BANK frames of BINS_PER_FFT
// bins. Full/release handshakes with the readout side decide whether the next
// bank may be written. When the next bank is still full, the default build
// applies backpressure (WAIT).
// Optional macro FFT_BANK_WRITER_DROP_EN: when defined, the writer keeps
// accepting beats while no bank is free. It discards those frames and counts
// them in dropped_frames (DROP state) instead of stalling.
module fft_bank_writer #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 12,
  parameter int BINS_PER_FFT  = 128,
  parameter int FFTS_PER_BANK = 32,
  parameter int NO_BANKS      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic                     wr_en,
  output logic [NO_BANKS-1:0]      wr_bank_sel,
  output logic [ADDRESS_WIDTH-1:0] wr_address,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic [NO_BANKS-1:0]      bank_full,
  input  logic [NO_BANKS-1:0]      bank_release,
  output logic                     frame_err,
  output logic [15:0]              dropped_frames
);

  localparam int SW = $clog2(BINS_PER_FFT);
  localparam int FW = (FFTS_PER_BANK > 1) ? $clog2(FFTS_PER_BANK) : 1;
  localparam int BW = $clog2(NO_BANKS);
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(BINS_PER_FFT - 1);
  localparam logic [FW-1:0] FFT_LAST = FW'(FFTS_PER_BANK - 1);
  localparam logic [BW-1:0] BANK_LAST = BW'(NO_BANKS - 1);
  localparam logic [ADDRESS_WIDTH-1:0] FRAME_STEP = ADDRESS_WIDTH'(BINS_PER_FFT);

  // Reject configurations whose bank cannot hold all of its frames.
  generate
    if (BINS_PER_FFT * FFTS_PER_BANK > 2 ** ADDRESS_WIDTH) begin : g_bad_depth
      $error("fft_bank_writer: BINS_PER_FFT*FFTS_PER_BANK exceeds 2**ADDRESS_WIDTH");
    end
    if (BINS_PER_FFT < 2) begin : g_bad_bins
      $error("fft_bank_writer: BINS_PER_FFT must be >= 2");
    end
    if (NO_BANKS < 2) begin : g_bad_banks
      $error("fft_bank_writer: NO_BANKS must be >= 2");
    end
  endgenerate

`ifdef FFT_BANK_WRITER_DROP_EN
  typedef enum logic [0:0] {S_WRITE = 1'b0, S_DROP = 1'b1} state_t;
`else
  typedef enum logic [0:0] {S_WRITE = 1'b0, S_WAIT = 1'b1} state_t;
`endif

  state_t                   state_q, state_d;
  logic [BW-1:0]            cur_bank_q, cur_bank_d;
  logic [SW-1:0]            sample_idx_q, sample_idx_d;
  logic [FW-1:0]            fft_idx_q, fft_idx_d;
  // addr_q is the running write address; base_q is the start of the current
  // frame, so a short frame can jump to the next frame base without a multiply.
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_WIDTH-1:0] base_q, base_d;
  logic                     wr_en_q, wr_en_d;
  logic [NO_BANKS-1:0]      wr_bank_sel_q, wr_bank_sel_d;
  logic [ADDRESS_WIDTH-1:0] wr_address_q, wr_address_d;
  logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
  logic [NO_BANKS-1:0]      bank_full_q, bank_full_d;
  logic                     frame_err_q, frame_err_d;

  logic                     accept;
  logic                     sample_last;
  logic                     frame_end;
  logic [BW-1:0]            next_bank;
  logic                     next_bank_busy;
  logic                     cur_free;
  logic [NO_BANKS-1:0]      cur_onehot;

`ifdef FFT_BANK_WRITER_DROP_EN
  logic [15:0]              drop_q, drop_d;
  assign in_ready       = 1'b1;
  assign dropped_frames = drop_q;
`else
  assign in_ready       = (state_q == S_WRITE);
  assign dropped_frames = 16'h0000;
`endif

  assign wr_en       = wr_en_q;
  assign wr_bank_sel = wr_bank_sel_q;
  assign wr_address  = wr_address_q;
  assign wr_data     = wr_data_q;
  assign bank_full   = bank_full_q;
  assign frame_err   = frame_err_q;

  // Next-state logic: frame/bank bookkeeping, write port and bank flags.
  always_comb begin
    state_d       = state_q;
    cur_bank_d    = cur_bank_q;
    sample_idx_d  = sample_idx_q;
    fft_idx_d     = fft_idx_q;
    addr_d        = addr_q;
    base_d        = base_q;
    wr_en_d       = 1'b0;
    wr_bank_sel_d = '0;
    wr_address_d  = wr_address_q;
    wr_data_d     = wr_data_q;
    frame_err_d   = 1'b0;
    // Releases clear flags; a completion set below overrides a same-cycle release.
    bank_full_d   = bank_full_q & ~bank_release;
`ifdef FFT_BANK_WRITER_DROP_EN
    drop_d        = drop_q;
`endif

    accept         = in_valid && in_ready;
    sample_last    = (sample_idx_q == SAMPLE_LAST);
    frame_end      = accept && (in_last || sample_last);
    next_bank      = (cur_bank_q == BANK_LAST) ? '0 : cur_bank_q + 1'b1;
    next_bank_busy = bank_full_q[next_bank] && !bank_release[next_bank];
    cur_free       = !bank_full_q[cur_bank_q] || bank_release[cur_bank_q];
    cur_onehot     = '0;
    cur_onehot[cur_bank_q] = 1'b1;

    // Frame tracking runs on every accepted beat, written or dropped.
    if (accept) begin
      sample_idx_d = frame_end ? '0 : sample_idx_q + 1'b1;
      if (frame_end) begin
        frame_err_d = (in_last != sample_last);
      end
    end

    case (state_q)
      S_WRITE: begin
        if (accept) begin
          wr_en_d       = 1'b1;
          wr_bank_sel_d = cur_onehot;
          wr_address_d  = addr_q;
          wr_data_d     = in_data;
          if (frame_end) begin
            if (fft_idx_q == FFT_LAST) begin
              fft_idx_d               = '0;
              cur_bank_d              = next_bank;
              addr_d                  = '0;
              base_d                  = '0;
              bank_full_d[cur_bank_q] = 1'b1;
              if (next_bank_busy) begin
`ifdef FFT_BANK_WRITER_DROP_EN
                state_d = S_DROP;
`else
                state_d = S_WAIT;
`endif
              end
            end else begin
              fft_idx_d = fft_idx_q + 1'b1;
              base_d    = base_q + FRAME_STEP;
              addr_d    = base_q + FRAME_STEP;
            end
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
`ifdef FFT_BANK_WRITER_DROP_EN
      S_DROP: begin
        // Resume only on a frame boundary so the bank starts with a whole frame.
        if (frame_end) begin
          if (drop_q != 16'hFFFF) begin
            drop_d = drop_q + 1'b1;
          end
          if (cur_free) begin
            state_d = S_WRITE;
          end
        end
      end
`else
      S_WAIT: begin
        if (cur_free) begin
          state_d = S_WRITE;
        end
      end
`endif
      default: state_d = S_WRITE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_WRITE;
      cur_bank_q    <= '0;
      sample_idx_q  <= '0;
      fft_idx_q     <= '0;
      addr_q        <= '0;
      base_q        <= '0;
      wr_en_q       <= 1'b0;
      wr_bank_sel_q <= '0;
      wr_address_q  <= '0;
      wr_data_q     <= '0;
      bank_full_q   <= '0;
      frame_err_q   <= 1'b0;
`ifdef FFT_BANK_WRITER_DROP_EN
      drop_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cur_bank_q    <= cur_bank_d;
      sample_idx_q  <= sample_idx_d;
      fft_idx_q     <= fft_idx_d;
      addr_q        <= addr_d;
      base_q        <= base_d;
      wr_en_q       <= wr_en_d;
      wr_bank_sel_q <= wr_bank_sel_d;
      wr_address_q  <= wr_address_d;
      wr_data_q     <= wr_data_d;
      bank_full_q   <= bank_full_d;
      frame_err_q   <= frame_err_d;
`ifdef FFT_BANK_WRITER_DROP_EN
      drop_q        <= drop_d;
`endif
    end
  end

endmodule
